uart_duplex_param: RTL

//  Parametrised full-duplex UART, successor to the fixed 8N1 core. Configurable

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_duplex_param.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encodings and parity helper for the duplex UART
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Payload is zero-extended to 9 bits; the extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversampling tick generator shared by the TX and RX engines
module uart_baud_gen #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_baud_gen: CLK_FREQ too low for BAUD*OVERSAMPLE");
        end
    endgenerate

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // With DIV == 1 the counter is pinned at zero and tick is asserted every clock.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_duplex_param.sv
// rtl/uart_duplex_param.sv - parametrised full-duplex UART with parity and framing checks
module uart_duplex_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err
);

    generate
        if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
            $error("uart_duplex_param: illegal parameter combination");
        end
    endgenerate

    localparam int            TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] OS_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] OS_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);
    localparam bit            HAS_PAR = (PARITY != PARITY_NONE);

    logic tick;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    tx_state_t              tx_state_q, tx_state_d;
    logic [TW-1:0]          tx_cnt_q, tx_cnt_d;
    logic [3:0]             tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_q, tx_line_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_bit_end;

    assign tx_bit_end = tick && (tx_cnt_q == OS_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tick ? ((tx_cnt_q == OS_LAST) ? '0 : tx_cnt_q + 1'b1) : tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = parity_bit(9'(tx_data), PARITY);
                    tx_idx_d   = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == DB_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_idx_d   = '0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == SB_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line value is derived from the next state so the pin itself is a flop.
    always_comb begin
        tx_line_d = 1'b1;
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
        tx_busy_d = (tx_state_d != TX_IDLE);
        tx_done_d = (tx_state_q == TX_STOP) && (tx_state_d == TX_IDLE);
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

    rx_state_t              rx_state_q, rx_state_d;
    logic [TW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [3:0]             rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_s1_q, rx_s2_q;
    logic                   rx_armed_q;
    logic                   rx_sample, rx_fin;
    logic [TW-1:0]          rx_target;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_done_q, parity_err_q, frame_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_target = (rx_state_q == RX_START) ? OS_HALF : OS_LAST;
    assign rx_sample = tick && (rx_cnt_q == rx_target);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = tick ? (rx_sample ? '0 : rx_cnt_q + 1'b1) : rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_armed_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_idx_d   = '0;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    rx_idx_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == DB_LAST) begin
                        rx_idx_d   = '0;
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = rx_s2_q ^ parity_bit(9'(rx_shift_q), PARITY);
                    rx_state_d = RX_STOP;
                    rx_idx_d   = '0;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_ferr_d = rx_ferr_q | ~rx_s2_q;
                    if (rx_idx_q == SB_LAST) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_fin = (rx_state_q == RX_STOP) && rx_sample && (rx_idx_q == SB_LAST);
    end

    // Armed drops at frame completion so a held-low line (break) cannot retrigger.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_armed_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_done_q <= rx_fin;
            if (rx_fin) begin
                rx_armed_q   <= 1'b0;
                rx_data_q    <= rx_shift_q;
                parity_err_q <= rx_perr_q;
                frame_err_q  <= rx_ferr_d;
            end else if (rx_s2_q) begin
                rx_armed_q <= 1'b1;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
